// File: rtl/axis_multiport_packet_source_if.sv
`default_nettype none
//==============================================================================
// Module      : axis_multiport_packet_source_if
// Description : Bundle of per-port request inputs and AXI-Stream master outputs
//               for the multiport packet source. The master modport is the
//               generator side; the slave modport is the side that issues
//               requests and sinks the streams.
// Revision    : 1.0 - initial release
//==============================================================================
interface axis_multiport_packet_source_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BYTES = 8,
  parameter int MTU_BYTES  = 1500,
  parameter int USER_WIDTH = 1
) ();

  logic [NUM_PORTS-1:0]              send_packet_req;
  logic [NUM_PORTS*16-1:0]           packet_byte_length;
  logic [NUM_PORTS*USER_WIDTH-1:0]   packet_user;
  logic [NUM_PORTS*MTU_BYTES*8-1:0]  packet_data;
  logic [NUM_PORTS-1:0]              busy;
  logic [NUM_PORTS-1:0]              axis_tvalid;
  logic [NUM_PORTS-1:0]              axis_tready;
  logic [NUM_PORTS*DATA_BYTES*8-1:0] axis_tdata;
  logic [NUM_PORTS*DATA_BYTES-1:0]   axis_tkeep;
  logic [NUM_PORTS-1:0]              axis_tlast;
  logic [NUM_PORTS*USER_WIDTH-1:0]   axis_tuser;

  modport master (
    input  send_packet_req, packet_byte_length, packet_user, packet_data, axis_tready,
    output busy, axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_tuser
  );

  modport slave (
    output send_packet_req, packet_byte_length, packet_user, packet_data, axis_tready,
    input  busy, axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_tuser
  );

endinterface
`default_nettype wire

// File: rtl/axis_multiport_packet_source.sv
`default_nettype none
//==============================================================================
// Module      : axis_multiport_packet_source
// Description : NUM_PORTS independent AXI-Stream packet generators. Each port
//               captures a packet image, byte length and user value on a
//               request and streams it as back-to-back beats honouring tready.
//               Optional macro AXIS_PKTGEN_PKT_COUNT_EN adds a per-port 32-bit
//               count of completed packets on output pkt_count.
// Revision    : 1.0 - initial release
//==============================================================================
module axis_multiport_packet_source #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BYTES = 8,
  parameter int MTU_BYTES  = 1500,
  parameter int USER_WIDTH = 1
) (
  input  wire logic                      clk,
  input  wire logic                      aresetn,
  axis_multiport_packet_source_if.master bus
`ifdef AXIS_PKTGEN_PKT_COUNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]        pkt_count
`endif
);

  localparam int          c_IMG_W  = MTU_BYTES * 8;
  localparam int          c_BEAT_W = DATA_BYTES * 8;
  localparam logic [16:0] c_MTU    = 17'(MTU_BYTES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_IMG_W-1:0]      r_img;
    logic [15:0]             r_beats_left;
    logic [DATA_BYTES-1:0]   r_last_keep;
    logic [USER_WIDTH-1:0]   r_user;

    logic [15:0]             w_len;
    logic [15:0]             w_rem;
    logic [15:0]             w_beats;
    logic                    w_len_ok;
    logic                    w_start;
    logic                    w_valid;
    logic                    w_last;
    logic                    w_fire;
    logic [DATA_BYTES-1:0]   w_last_keep_nxt;
    logic [DATA_BYTES-1:0]   w_keep;

    assign w_len    = bus.packet_byte_length[16*p +: 16];
    assign w_len_ok = (w_len != 16'd0) && ({1'b0, w_len} <= c_MTU);
    assign w_beats  = 16'(({1'b0, w_len} + 17'(DATA_BYTES - 1)) / 17'(DATA_BYTES));
    assign w_rem    = w_len % 16'(DATA_BYTES);
    assign w_last   = (r_beats_left == 16'd0);
    assign w_fire   = w_valid & bus.axis_tready[p];

    // Final-beat byte enables: low (len mod DATA_BYTES) lanes, or all lanes when it divides evenly
    always_comb begin
      w_last_keep_nxt = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
        w_last_keep_nxt[i] = (w_rem == 16'd0) || (16'(i) < w_rem);
      end
    end

    // State register; an asynchronous reset aborts any packet in flight
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        r_state <= S_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // Next-state and handshake decode: accept valid requests in IDLE, leave SEND on last handshake
    always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_valid     = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.send_packet_req[p] && w_len_ok) begin
            w_start     = 1'b1;
            w_state_nxt = S_SEND;
          end
        end
        S_SEND: begin
          w_valid = 1'b1;
          if (bus.axis_tready[p] && w_last) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Per-packet context: remaining beats, final-beat keep and user, loaded at acceptance
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        r_beats_left <= '0;
        r_last_keep  <= '0;
        r_user       <= '0;
      end else if (w_start) begin
        r_beats_left <= w_beats - 16'd1;
        r_last_keep  <= w_last_keep_nxt;
        r_user       <= bus.packet_user[USER_WIDTH*p +: USER_WIDTH];
      end else if (w_fire && !w_last) begin
        r_beats_left <= r_beats_left - 16'd1;
      end
    end

    // Packet image: captured whole, then shifted so the current beat always sits in the top bytes.
    // Outputs are gated by the reset-cleared state, so this register needs no reset.
    always_ff @(posedge clk) begin
      if (w_start) begin
        r_img <= bus.packet_data[c_IMG_W*p +: c_IMG_W];
      end else if (w_fire) begin
        r_img <= r_img << c_BEAT_W;
      end
    end

    assign w_keep = !w_valid ? '0 : (w_last ? r_last_keep : '1);

    assign bus.busy[p]        = w_valid;
    assign bus.axis_tvalid[p] = w_valid;
    assign bus.axis_tlast[p]  = w_valid & w_last;
    assign bus.axis_tkeep[DATA_BYTES*p +: DATA_BYTES] = w_keep;
    assign bus.axis_tuser[USER_WIDTH*p +: USER_WIDTH] = w_valid ? r_user : '0;

    // Packet byte i of the beat (i-th byte from the top of the image) goes to lane i; disabled lanes read 0
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
      assign bus.axis_tdata[c_BEAT_W*p + 8*i +: 8] =
        w_keep[i] ? r_img[c_IMG_W-1-8*i -: 8] : 8'h00;
    end

`ifdef AXIS_PKTGEN_PKT_COUNT_EN
    logic [31:0] r_pkt_cnt;

    // Completed-packet counter, advanced on each tlast handshake, wraps naturally
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        r_pkt_cnt <= '0;
      end else if (w_fire && w_last) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end

    assign pkt_count[32*p +: 32] = r_pkt_cnt;
`endif

  end

endmodule
`default_nettype wire

// File: tb/tb_axis_multiport_packet_source.sv
`default_nettype none
//==============================================================================
// Module      : tb_axis_multiport_packet_source
// Description : Scoreboard bench for axis_multiport_packet_source. Expected
//               beats are queued per port when a request is driven and
//               compared as the DUT hands beats off.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_axis_multiport_packet_source;

  localparam int NP     = 4;
  localparam int DB     = 8;
  localparam int MTU    = 1500;
  localparam int UW     = 1;
  localparam int IMG_W  = MTU * 8;
  localparam int BW     = DB * 8;
  localparam int BEAT_W = BW + DB + 1 + UW;

  typedef logic [BEAT_W-1:0] beat_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  beat_t exp_q [NP][$];
  int    beats_seen [NP];
  int    n_last [NP];
  int    sent [NP];
  bit    stall [NP];
  beat_t held [NP];
  bit    chk_fall [NP];
  bit    rmode [NP];

  axis_multiport_packet_source_if #(
    .NUM_PORTS(NP), .DATA_BYTES(DB), .MTU_BYTES(MTU), .USER_WIDTH(UW)
  ) bus_if ();

`ifdef AXIS_PKTGEN_PKT_COUNT_EN
  logic [NP*32-1:0] pkt_count;
`endif

  axis_multiport_packet_source #(
    .NUM_PORTS(NP), .DATA_BYTES(DB), .MTU_BYTES(MTU), .USER_WIDTH(UW)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus_if)
`ifdef AXIS_PKTGEN_PKT_COUNT_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t cur_beat(input int p);
    return {bus_if.axis_tuser[p*UW +: UW], bus_if.axis_tlast[p],
            bus_if.axis_tkeep[p*DB +: DB], bus_if.axis_tdata[p*BW +: BW]};
  endfunction

  // Ready generator: per port either always ready or random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        bus_if.axis_tready[p] = rmode[p] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: sampled mid-cycle, compares handshaked beats, stability under stall and busy drop
  initial begin
    beat_t cb;
    beat_t eb;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        cb = cur_beat(p);
        if (chk_fall[p]) begin
          check($sformatf("p%0d_busy_fall", p), 128'({bus_if.busy[p], bus_if.axis_tvalid[p]}), 128'(0));
          chk_fall[p] = 1'b0;
        end
        if (stall[p]) begin
          check($sformatf("p%0d_stable", p), 128'(cb), 128'(held[p]));
        end
        stall[p] = bus_if.axis_tvalid[p] & ~bus_if.axis_tready[p];
        held[p]  = cb;
        if (bus_if.axis_tvalid[p] && bus_if.axis_tready[p]) begin
          beats_seen[p]++;
          if (exp_q[p].size() == 0) begin
            check($sformatf("p%0d_extra_beat", p), 128'(cb), 128'(0));
          end else begin
            eb = exp_q[p].pop_front();
            check($sformatf("p%0d_beat", p), 128'(cb), 128'(eb));
          end
          if (bus_if.axis_tlast[p]) begin
            n_last[p]++;
            chk_fall[p] = 1'b1;
          end
        end
      end
    end
  end

  // Build a random image, queue its expected beats, issue the request and drop it once busy
  task automatic start_pkt(input int p, input int len, input logic [UW-1:0] u,
                           output int base, output int nb);
    logic [IMG_W-1:0] img;
    logic [BW-1:0]    d;
    logic [DB-1:0]    k;
    beat_t            e;
    for (int i = 0; i < MTU; i++) img[IMG_W-1-8*i -: 8] = 8'($urandom);
    nb = (len + DB - 1) / DB;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      k = '0;
      for (int i = 0; i < DB; i++) begin
        if (b*DB + i < len) begin
          d[8*i +: 8] = img[IMG_W-1-8*(b*DB+i) -: 8];
          k[i] = 1'b1;
        end
      end
      e = {u, (b == nb - 1), k, d};
      exp_q[p].push_back(e);
    end
    base = beats_seen[p];
    sent[p]++;
    bus_if.packet_data[p*IMG_W +: IMG_W]   = img;
    bus_if.packet_byte_length[p*16 +: 16]  = 16'(len);
    bus_if.packet_user[p*UW +: UW]         = u;
    bus_if.send_packet_req[p]              = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("p%0d_busy_lat", p), 128'(bus_if.busy[p]), 128'(1));
    bus_if.send_packet_req[p]            = 1'b0;
    bus_if.packet_data[p*IMG_W +: IMG_W] = ~img;
    bus_if.packet_user[p*UW +: UW]       = ~u;
  endtask

  task automatic finish_pkt(input int p, input int base, input int nb);
    int t = 0;
    while (bus_if.busy[p] === 1'b1 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check($sformatf("p%0d_done_timeout", p), 128'(t >= 5000), 128'(0));
    check($sformatf("p%0d_beat_count", p), 128'(beats_seen[p] - base), 128'(nb));
    check($sformatf("p%0d_q_empty", p), 128'(exp_q[p].size()), 128'(0));
  endtask

  task automatic send_pkt(input int p, input int len, input logic [UW-1:0] u);
    int base;
    int nb;
    start_pkt(p, len, u, base, nb);
    finish_pkt(p, base, nb);
  endtask

  task automatic run_port(input int p);
    for (int n = 0; n < 25; n++) begin
      send_pkt(p, int'($urandom_range(64, 1500)), UW'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int nb0;
    int t;
    int nl0 [NP];

    bus_if.send_packet_req    = '0;
    bus_if.packet_byte_length = '0;
    bus_if.packet_user        = '0;
    bus_if.packet_data        = '0;
    bus_if.axis_tready        = '1;
    for (int p = 0; p < NP; p++) begin
      rmode[p] = 1'b0;
      beats_seen[p] = 0;
      n_last[p] = 0;
      sent[p] = 0;
      stall[p] = 1'b0;
      chk_fall[p] = 1'b0;
    end

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("p%0d_rst_state", p),
            128'({bus_if.busy[p], bus_if.axis_tvalid[p], bus_if.axis_tlast[p]}), 128'(0));
    end
    check("rst_keep_data", 128'({bus_if.axis_tkeep, bus_if.axis_tdata[63:0]}), 128'(0));
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Directed packets
    send_pkt(0, 64, 1'b1);
    send_pkt(1, 65, 1'b0);
    rmode[2] = 1'b1;
    send_pkt(2, 1500, 1'b1);
    rmode[2] = 1'b0;

    // All ports in parallel with random backpressure
    for (int p = 0; p < NP; p++) begin
      rmode[p] = 1'b1;
      nl0[p]   = n_last[p];
    end
    fork
      run_port(0);
      run_port(1);
      run_port(2);
      run_port(3);
    join
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("p%0d_tlast_count", p), 128'(n_last[p] - nl0[p]), 128'(25));
`ifdef AXIS_PKTGEN_PKT_COUNT_EN
      check($sformatf("p%0d_pkt_count", p), 128'(pkt_count[32*p +: 32]), 128'(sent[p]));
`endif
      rmode[p] = 1'b0;
    end

    // Out-of-range lengths are ignored
    bus_if.packet_byte_length[3*16 +: 16] = 16'd0;
    bus_if.send_packet_req[3] = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("p3_len0_idle", 128'({bus_if.busy[3], bus_if.axis_tvalid[3]}), 128'(0));
    end
    bus_if.packet_byte_length[3*16 +: 16] = 16'd1501;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("p3_len1501_idle", 128'({bus_if.busy[3], bus_if.axis_tvalid[3]}), 128'(0));
    end
    bus_if.send_packet_req[3] = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset while beat 5 of a port 0 packet is presented
    start_pkt(0, 64, 1'b1, b0, nb0);
    t = 0;
    while ((beats_seen[0] - b0) < 4 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("p0_reach_beat5", 128'(beats_seen[0] - b0), 128'(4));
    check("p0_beat5_valid", 128'(bus_if.axis_tvalid[0]), 128'(1));
    #1;
    aresetn = 1'b0;
    #1;
    check("p0_async_rst_ctl",
          128'({bus_if.busy[0], bus_if.axis_tvalid[0], bus_if.axis_tlast[0]}), 128'(0));
    check("p0_async_rst_bus",
          128'({bus_if.axis_tkeep[DB-1:0], bus_if.axis_tdata[BW-1:0]}), 128'(0));
    exp_q[0].delete();
    @(posedge clk);
    #1;
`ifdef AXIS_PKTGEN_PKT_COUNT_EN
    check("p0_pkt_count_rst", 128'(pkt_count[31:0]), 128'(0));
`endif
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(0, 64, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
